// File: rtl/dom_pkg.sv
// Shared helpers for DOM masked gadgets: random-bit count and share-pair indexing.
package dom_pkg;

    localparam int unsigned MAX_SHARES = 8;

    // Number of fresh random bits per lane for n shares.
    function automatic int unsigned nrand(input int unsigned n);
        return (n * (n - 1)) / 2;
    endfunction

    // Linear index of share pair (i,j) with i<j, row-major over the upper triangle.
    function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j,
                                             input int unsigned n);
        return (i * n) - ((i * (i + 1)) / 2) + (j - i - 1);
    endfunction

endpackage

// File: rtl/dom_and_lane.sv
// One bit lane of the DOM AND: NSHARES^2 resharing flops followed by per-domain compression.
module dom_and_lane
    import dom_pkg::*;
#(
    parameter int unsigned NSHARES = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                load,
    input  logic [NSHARES-1:0]                  a,
    input  logic [NSHARES-1:0]                  b,
    input  logic [nrand(NSHARES)-1:0]           z,
    output logic [NSHARES-1:0]                  c
);

    localparam int unsigned NSQ = NSHARES * NSHARES;

    logic [NSQ-1:0] r_all;

    // Each product term gets its own kept flop so no domain mixing happens before the register.
    for (genvar gi = 0; gi < NSHARES; gi++) begin : g_row
        for (genvar gj = 0; gj < NSHARES; gj++) begin : g_col
            logic r_d;
            (* keep = "true" *) logic r_q;

            if (gi == gj) begin : g_inner
                assign r_d = a[gi] & b[gj];
            end else begin : g_cross
                localparam int unsigned K = (gi < gj) ? pair_idx(gi, gj, NSHARES)
                                                      : pair_idx(gj, gi, NSHARES);
                assign r_d = (a[gi] & b[gj]) ^ z[K];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= 1'b0;
                end else if (load) begin
                    r_q <= r_d;
                end
            end

            assign r_all[gi*NSHARES+gj] = r_q;
        end

        // Domain gi compresses only its own registered row, ascending j.
        assign c[gi] = ^r_all[gi*NSHARES +: NSHARES];
    end

endmodule

// File: rtl/dom_and_pipe.sv
// Pipelined DOM AND gadget over NSHARES shares and WIDTH lanes with valid/ready flow control.
module dom_and_pipe
    import dom_pkg::*;
#(
    parameter int unsigned NSHARES  = 3,
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned PIPE_OUT = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NSHARES*WIDTH-1:0]            a_i,
    input  logic [NSHARES*WIDTH-1:0]            b_i,
    input  logic [nrand(NSHARES)*WIDTH-1:0]     z_i,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NSHARES*WIDTH-1:0]            c_o
);

    localparam int unsigned NR = nrand(NSHARES);
    localparam int unsigned CW = NSHARES * WIDTH;

    logic          v1;
    logic          adv1;
    logic          accept;
    logic [CW-1:0] comp;

    assign accept   = in_valid && adv1;
    assign in_ready = adv1;

    // Unpack share-major buses into per-lane vectors.
    for (genvar gl = 0; gl < WIDTH; gl++) begin : g_lane
        logic [NSHARES-1:0] a_l;
        logic [NSHARES-1:0] b_l;
        logic [NSHARES-1:0] c_l;
        logic [NR-1:0]      z_l;

        for (genvar gs = 0; gs < NSHARES; gs++) begin : g_sh
            assign a_l[gs]           = a_i[gs*WIDTH+gl];
            assign b_l[gs]           = b_i[gs*WIDTH+gl];
            assign comp[gs*WIDTH+gl] = c_l[gs];
        end

        for (genvar gk = 0; gk < NR; gk++) begin : g_rnd
            assign z_l[gk] = z_i[gk*WIDTH+gl];
        end

        dom_and_lane #(
            .NSHARES (NSHARES)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (accept),
            .a     (a_l),
            .b     (b_l),
            .z     (z_l),
            .c     (c_l)
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
        end else if (adv1) begin
            v1 <= in_valid;
        end
    end

    if (PIPE_OUT != 0) begin : g_pipe
        logic          v2;
        logic          adv2;
        logic [CW-1:0] c_q;

        assign adv2 = !v2 || out_ready;
        assign adv1 = !v1 || adv2;

        // Compression register holds on bubbles instead of clearing.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v2  <= 1'b0;
                c_q <= '0;
            end else if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    c_q <= comp;
                end
            end
        end

        assign out_valid = v2;
        assign c_o       = c_q;
    end else begin : g_comb
        assign adv1      = !v1 || out_ready;
        assign out_valid = v1;
        assign c_o       = comp;
    end

endmodule
